// File: rtl/nt_bist_driver.sv
// BIST driver for one nonterminal-node subcircuit: LFSR stimulus out, single-bit
// response compacted into a MISR and compared against a golden signature.
module nt_bist_driver #(
  parameter int unsigned             STIM_W = 7,
  parameter logic [STIM_W-1:0]       TAPS   = 7'b1100000,
  parameter logic [STIM_W-1:0]       SEED   = 7'h01,
  parameter int unsigned             N_VEC  = 64,
  parameter int unsigned             LAT    = 2,
  parameter int unsigned             SIG_W  = 16
) (
  input  logic              I1470_clk,
  input  logic              I1477_rst,
  input  logic              start,
  input  logic              abort,
  input  logic [SIG_W-1:0]  golden_sig,
  input  logic              dut_resp,
  output logic [STIM_W-1:0] stim_o,
  output logic              stim_valid,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [SIG_W-1:0]  signature
);

  localparam logic [SIG_W-1:0] POLY       = SIG_W'(16'h1021);
  localparam logic [15:0]      LAST_VEC   = 16'(N_VEC - 1);
  localparam logic [2:0]       LAST_DRAIN = 3'(LAT - 1);

  typedef enum logic [1:0] {StIdle, StDrive, StDrain, StDone} state_e;

  state_e              state_q, state_d;
  logic [STIM_W-1:0]   lfsr_q, lfsr_d;
  logic [STIM_W-1:0]   stim_q, stim_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [2:0]          drain_q, drain_d;
  logic [LAT-1:0]      vpipe_q, vpipe_d;
  logic [SIG_W-1:0]    sig_q, sig_d;
  logic                fb;

  assign stim_valid = (state_q == StDrive);
  assign busy       = (state_q == StDrive) || (state_q == StDrain);
  assign done       = (state_q == StDone);
  assign pass       = done && (sig_q == golden_sig);
  assign signature  = sig_q;
  // Live LFSR value while driving; otherwise hold the last presented vector.
  assign stim_o     = stim_valid ? lfsr_q : stim_q;
  assign fb         = sig_q[SIG_W-1] ^ dut_resp;

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    stim_d     = stim_q;
    cnt_d      = cnt_q;
    drain_d    = drain_q;
    sig_d      = sig_q;
    vpipe_d[0] = stim_valid;
    for (int i = 1; i < int'(LAT); i++) begin
      vpipe_d[i] = vpipe_q[i-1];
    end

    // Abort freezes the MISR in the cycle it is seen.
    if (busy && !abort && vpipe_q[LAT-1]) begin
      sig_d = {sig_q[SIG_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StDrive;
          lfsr_d  = SEED;
          cnt_d   = '0;
          sig_d   = '1;
          vpipe_d = '0;
        end
      end
      StDrive: begin
        stim_d = lfsr_q;
        if (abort) begin
          state_d = StIdle;
          vpipe_d = '0;
        end else begin
          lfsr_d = {lfsr_q[STIM_W-2:0], ^(lfsr_q & TAPS)};
          cnt_d  = cnt_q + 16'd1;
          if (cnt_q == LAST_VEC) begin
            state_d = StDrain;
            drain_d = '0;
          end
        end
      end
      StDrain: begin
        if (abort) begin
          state_d = StIdle;
          vpipe_d = '0;
        end else if (drain_q == LAST_DRAIN) begin
          state_d = StDone;
        end else begin
          drain_d = drain_q + 3'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge I1470_clk or posedge I1477_rst) begin
    if (I1477_rst) begin
      state_q <= StIdle;
      lfsr_q  <= SEED;
      stim_q  <= '0;
      cnt_q   <= '0;
      drain_q <= '0;
      vpipe_q <= '0;
      sig_q   <= '1;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      stim_q  <= stim_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      vpipe_q <= vpipe_d;
      sig_q   <= sig_d;
    end
  end

endmodule

// File: tb/tb_nt_bist_driver.sv
// Directed bench for nt_bist_driver: four instances with different run lengths,
// each scenario task checks its own expectations inline.
module tb_nt_bist_driver;

  logic clk;
  logic rst;

  logic        start8, abort8, resp8, valid8, busy8, done8, pass8;
  logic [15:0] gold8, sig8;
  logic [6:0]  stim8;
  logic        start1, abort1, resp1, valid1, busy1, done1, pass1;
  logic [15:0] gold1, sig1;
  logic [6:0]  stim1;
  logic        start128, abort128, resp128, valid128, busy128, done128, pass128;
  logic [15:0] gold128, sig128;
  logic [6:0]  stim128;
  logic        start64, abort64, resp64, valid64, busy64, done64, pass64;
  logic [15:0] gold64, sig64;
  logic [6:0]  stim64;

  int n_checks;
  int n_fail;

  logic [6:0] exp_vec [8];

  nt_bist_driver #(.N_VEC(8)) u_dut8 (
    .I1470_clk(clk), .I1477_rst(rst), .start(start8), .abort(abort8),
    .golden_sig(gold8), .dut_resp(resp8), .stim_o(stim8), .stim_valid(valid8),
    .busy(busy8), .done(done8), .pass(pass8), .signature(sig8)
  );
  nt_bist_driver #(.N_VEC(1)) u_dut1 (
    .I1470_clk(clk), .I1477_rst(rst), .start(start1), .abort(abort1),
    .golden_sig(gold1), .dut_resp(resp1), .stim_o(stim1), .stim_valid(valid1),
    .busy(busy1), .done(done1), .pass(pass1), .signature(sig1)
  );
  nt_bist_driver #(.N_VEC(128)) u_dut128 (
    .I1470_clk(clk), .I1477_rst(rst), .start(start128), .abort(abort128),
    .golden_sig(gold128), .dut_resp(resp128), .stim_o(stim128), .stim_valid(valid128),
    .busy(busy128), .done(done128), .pass(pass128), .signature(sig128)
  );
  nt_bist_driver #(.N_VEC(64)) u_dut64 (
    .I1470_clk(clk), .I1477_rst(rst), .start(start64), .abort(abort64),
    .golden_sig(gold64), .dut_resp(resp64), .stim_o(stim64), .stim_valid(valid64),
    .busy(busy64), .done(done64), .pass(pass64), .signature(sig64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] misr(input logic [15:0] s, input logic r);
    logic fbk;
    fbk = s[15] ^ r;
    return {s[14:0], 1'b0} ^ (fbk ? 16'h1021 : 16'h0000);
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    n_checks++; if (stim8 !== 7'h00) begin n_fail++; $display("FAIL rst_stim got %h exp 00", stim8); end
    n_checks++; if (valid8 !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", valid8); end
    n_checks++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy8); end
    n_checks++; if (done8 !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b exp 0", done8); end
    n_checks++; if (pass8 !== 1'b0) begin n_fail++; $display("FAIL rst_pass got %b exp 0", pass8); end
    n_checks++; if (sig8 !== 16'hFFFF) begin n_fail++; $display("FAIL rst_sig got %h exp FFFF", sig8); end
    rst = 1'b0;
    step();
  endtask

  // Eight vectors with response tied high; signature from a reference MISR fold.
  task automatic test_sequence();
    logic [15:0] exp_sig;
    exp_sig = 16'hFFFF;
    for (int i = 0; i < 8; i++) exp_sig = misr(exp_sig, 1'b1);
    resp8  = 1'b1;
    gold8  = exp_sig;
    start8 = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      start8 = 1'b0;
      n_checks++;
      if (stim8 !== exp_vec[c-1] || valid8 !== 1'b1) begin
        n_fail++;
        $display("FAIL seq_vec%0d got %h/%b exp %h/1", c, stim8, valid8, exp_vec[c-1]);
      end
    end
    step();
    n_checks++; if (valid8 !== 1'b0 || stim8 !== 7'h03 || busy8 !== 1'b1) begin
      n_fail++; $display("FAIL seq_drain got valid=%b stim=%h busy=%b exp 0/03/1", valid8, stim8, busy8); end
    step();
    n_checks++; if (done8 !== 1'b0) begin n_fail++; $display("FAIL seq_early_done got %b exp 0", done8); end
    step();
    n_checks++; if (done8 !== 1'b1 || busy8 !== 1'b0) begin
      n_fail++; $display("FAIL seq_done got done=%b busy=%b exp 1/0", done8, busy8); end
    n_checks++; if (sig8 !== exp_sig || pass8 !== 1'b1) begin
      n_fail++; $display("FAIL seq_sig got %h pass=%b exp %h pass=1", sig8, pass8, exp_sig); end
  endtask

  task automatic test_pass_fail();
    resp1  = 1'b0;
    gold1  = 16'hEFDF;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    step();
    step();
    n_checks++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL pf_early_done got %b exp 0", done1); end
    step();
    n_checks++; if (done1 !== 1'b1 || pass1 !== 1'b1 || sig1 !== 16'hEFDF) begin
      n_fail++; $display("FAIL pf_pass got done=%b pass=%b sig=%h exp 1/1/EFDF", done1, pass1, sig1); end
    gold1 = 16'h0000;
    #1;
    n_checks++; if (pass1 !== 1'b0) begin n_fail++; $display("FAIL pf_fail got %b exp 0", pass1); end
  endtask

  task automatic test_restart();
    gold1  = 16'hEFDF;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    n_checks++; if (done1 !== 1'b0 || busy1 !== 1'b1 || valid1 !== 1'b1 || stim1 !== 7'h01) begin
      n_fail++; $display("FAIL rs_begin got done=%b busy=%b valid=%b stim=%h exp 0/1/1/01",
                         done1, busy1, valid1, stim1); end
    step();
    step();
    step();
    n_checks++; if (done1 !== 1'b1 || sig1 !== 16'hEFDF || pass1 !== 1'b1) begin
      n_fail++; $display("FAIL rs_repeat got done=%b sig=%h pass=%b exp 1/EFDF/1", done1, sig1, pass1); end
  endtask

  task automatic test_wrap();
    resp128  = 1'b0;
    start128 = 1'b1;
    for (int c = 1; c <= 128; c++) begin
      step();
      start128 = 1'b0;
    end
    n_checks++; if (stim128 !== 7'h01 || valid128 !== 1'b1) begin
      n_fail++; $display("FAIL wrap_vec127 got %h/%b exp 01/1", stim128, valid128); end
    step();
    n_checks++; if (valid128 !== 1'b0) begin n_fail++; $display("FAIL wrap_valid_drop got %b exp 0", valid128); end
    step();
    n_checks++; if (done128 !== 1'b0) begin n_fail++; $display("FAIL wrap_early_done got %b exp 0", done128); end
    step();
    n_checks++; if (done128 !== 1'b1) begin n_fail++; $display("FAIL wrap_done got %b exp 1", done128); end
  endtask

  // Response tied low: delayed-valid folds in cycles 3 and 4; cycle 5 carries abort.
  task automatic test_abort();
    logic [15:0] exp_sig;
    exp_sig = misr(misr(16'hFFFF, 1'b0), 1'b0);
    resp64  = 1'b0;
    gold64  = 16'h0000;
    start64 = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      step();
      start64 = 1'b0;
    end
    abort64 = 1'b1;
    start64 = 1'b1;
    step();
    abort64 = 1'b0;
    start64 = 1'b0;
    n_checks++; if (busy64 !== 1'b0 || valid64 !== 1'b0 || done64 !== 1'b0 || pass64 !== 1'b0) begin
      n_fail++; $display("FAIL ab_idle got busy=%b valid=%b done=%b pass=%b exp 0/0/0/0",
                         busy64, valid64, done64, pass64); end
    n_checks++; if (sig64 !== exp_sig) begin n_fail++; $display("FAIL ab_sig got %h exp %h", sig64, exp_sig); end
    abort64 = 1'b1;
    step();
    step();
    abort64 = 1'b0;
    n_checks++; if (busy64 !== 1'b0 || sig64 !== exp_sig || stim64 !== 7'h10) begin
      n_fail++; $display("FAIL ab_frozen got busy=%b sig=%h stim=%h exp 0/%h/10", busy64, sig64, stim64, exp_sig); end
  endtask

  task automatic test_busy_start();
    start64 = 1'b1;
    for (int c = 1; c <= 67; c++) begin
      step();
      start64 = (c == 3) || (c == 20);
      if (c <= 8) begin
        n_checks++;
        if (stim64 !== exp_vec[c-1] || valid64 !== 1'b1) begin
          n_fail++; $display("FAIL bs_vec%0d got %h/%b exp %h/1", c, stim64, valid64, exp_vec[c-1]);
        end
      end
      if (c == 66) begin
        n_checks++; if (done64 !== 1'b0 || busy64 !== 1'b1) begin
          n_fail++; $display("FAIL bs_early_done got done=%b busy=%b exp 0/1", done64, busy64); end
      end
      if (c == 67) begin
        n_checks++; if (done64 !== 1'b1 || busy64 !== 1'b0 || sig64 === 16'hFFFF) begin
          n_fail++; $display("FAIL bs_done got done=%b busy=%b sig=%h exp 1/0/not FFFF",
                             done64, busy64, sig64); end
      end
    end
  endtask

  task automatic test_async_reset();
    logic seen_done;
    seen_done = 1'b0;
    start64 = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
      start64 = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (stim64 !== 7'h00 || valid64 !== 1'b0 || busy64 !== 1'b0 ||
                    done64 !== 1'b0 || pass64 !== 1'b0 || sig64 !== 16'hFFFF) begin
      n_fail++; $display("FAIL ar_values got stim=%h valid=%b busy=%b done=%b pass=%b sig=%h",
                         stim64, valid64, busy64, done64, pass64, sig64); end
    step();
    rst = 1'b0;
    for (int c = 0; c < 80; c++) begin
      step();
      if (done64 !== 1'b0) seen_done = 1'b1;
    end
    n_checks++; if (seen_done !== 1'b0) begin n_fail++; $display("FAIL ar_no_done got 1 exp 0"); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_vec[0] = 7'h01; exp_vec[1] = 7'h02; exp_vec[2] = 7'h04; exp_vec[3] = 7'h08;
    exp_vec[4] = 7'h10; exp_vec[5] = 7'h20; exp_vec[6] = 7'h41; exp_vec[7] = 7'h03;
    rst = 1'b1;
    {start8, abort8, resp8, gold8} = '0;
    {start1, abort1, resp1, gold1} = '0;
    {start128, abort128, resp128, gold128} = '0;
    {start64, abort64, resp64, gold64} = '0;
    test_reset();
    test_sequence();
    test_pass_fail();
    test_restart();
    test_wrap();
    test_abort();
    test_busy_start();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
